// File: rtl/change_dispenser.sv
// change_dispenser: vend sequencer pulsing the soda motor and nickel ejector, counting confirmed coins.
// Optional COIN_WAIT timeout enabled by defining CHANGE_DISPENSER_TIMEOUT_EN.
module change_dispenser #(
  parameter int unsigned PULSE_CYCLES   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_soda,
  input  logic [2:0] req_change,
  output logic       soda_motor,
  output logic       coin_eject,
  input  logic       coin_sensed,
  output logic       done,
  output logic       fault,
  input  logic       fault_clr,
  output logic [7:0] paid_count
);

  localparam int unsigned PW = 4;
  localparam int unsigned CW = 3;
  localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] MAX_CHANGE = CW'(4);

  if (PULSE_CYCLES < 1 || PULSE_CYCLES > 15 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_params
    $error("change_dispenser: PULSE_CYCLES or TIMEOUT_CYCLES out of range");
  end

  typedef enum logic [2:0] {IDLE, VEND, COIN_PULSE, COIN_WAIT, DONE, FAULT} state_t;

  state_t        state;
  logic [CW-1:0] remaining;
  logic [PW-1:0] pulse_cnt;
`ifdef CHANGE_DISPENSER_TIMEOUT_EN
  localparam int unsigned TW = 8;
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] timeout_cnt;
`endif

  // Single registered FSM; every output is a flop so no input reaches an output combinationally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      soda_motor <= 1'b0;
      coin_eject <= 1'b0;
      done       <= 1'b0;
      fault      <= 1'b0;
      paid_count <= '0;
      remaining  <= '0;
      pulse_cnt  <= '0;
`ifdef CHANGE_DISPENSER_TIMEOUT_EN
      timeout_cnt <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            if (req_change > MAX_CHANGE) begin
              state     <= FAULT;
              fault     <= 1'b1;
              req_ready <= 1'b0;
            end else if (req_soda) begin
              state      <= VEND;
              soda_motor <= 1'b1;
              pulse_cnt  <= '0;
              remaining  <= req_change;
              req_ready  <= 1'b0;
            end else if (req_change != '0) begin
              state      <= COIN_PULSE;
              coin_eject <= 1'b1;
              pulse_cnt  <= '0;
              remaining  <= req_change;
              req_ready  <= 1'b0;
            end
          end
        end
        VEND: begin
          if (pulse_cnt == PULSE_LAST) begin
            soda_motor <= 1'b0;
            if (remaining != '0) begin
              state      <= COIN_PULSE;
              coin_eject <= 1'b1;
              pulse_cnt  <= '0;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end else begin
            pulse_cnt <= pulse_cnt + PW'(1);
          end
        end
        COIN_PULSE: begin
          if (pulse_cnt == PULSE_LAST) begin
            coin_eject <= 1'b0;
            state      <= COIN_WAIT;
            pulse_cnt  <= '0;
`ifdef CHANGE_DISPENSER_TIMEOUT_EN
            timeout_cnt <= '0;
`endif
          end else begin
            pulse_cnt <= pulse_cnt + PW'(1);
          end
        end
        COIN_WAIT: begin
          if (coin_sensed) begin
            remaining <= remaining - CW'(1);
            if (paid_count != 8'hFF) paid_count <= paid_count + 8'd1;
            if (remaining != CW'(1)) begin
              state      <= COIN_PULSE;
              coin_eject <= 1'b1;
              pulse_cnt  <= '0;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
`ifdef CHANGE_DISPENSER_TIMEOUT_EN
          else if (timeout_cnt == TIMEOUT_LAST) begin
            state     <= FAULT;
            fault     <= 1'b1;
            remaining <= '0;
          end else begin
            timeout_cnt <= timeout_cnt + TW'(1);
          end
`endif
        end
        DONE: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        FAULT: begin
          soda_motor <= 1'b0;
          coin_eject <= 1'b0;
          remaining  <= '0;
          if (fault_clr) begin
            state     <= IDLE;
            fault     <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          soda_motor <= 1'b0;
          coin_eject <= 1'b0;
          fault      <= 1'b0;
          remaining  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: random vend requests, outcome model feeding a scoreboard queue,
// and an independent monitor that measures pulses and completions on the DUT outputs.
module tb_change_dispenser;

  localparam int unsigned PULSE = 4;
  localparam int unsigned TMO   = 16;

  logic       clk;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic       req_soda;
  logic [2:0] req_change;
  logic       soda_motor;
  logic       coin_eject;
  logic       coin_sensed;
  logic       done;
  logic       fault;
  logic       fault_clr;
  logic [7:0] paid_count;

  change_dispenser #(.PULSE_CYCLES(PULSE), .TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_soda   (req_soda),
    .req_change (req_change),
    .soda_motor (soda_motor),
    .coin_eject (coin_eject),
    .coin_sensed(coin_sensed),
    .done       (done),
    .fault      (fault),
    .fault_clr  (fault_clr),
    .paid_count (paid_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit is_fault;
    int soda_pulses;
    int coin_pulses;
    int paid;
    int accept_cyc;
    int latency;
    bit tmo_chk;
  } exp_t;

  exp_t sb[$];
  int   n_checks;
  int   n_fail;
  int   cyc;
  int   paid_model;
  bit   hopper_en;
  bit   spur_en;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail_bound(input string name, input int lim);
    n_checks++;
    n_fail++;
    $display("FAIL %s: no response within %0d cycles (cycle %0d)", name, lim, cyc);
  endtask

  // Asynchronous reset mid-cycle; outputs must be at reset values before the next clock edge.
  task automatic reset_pulse();
    #2 reset = 1'b1;
    #1;
    check("rst_coin_eject", coin_eject, 0);
    check("rst_soda_motor", soda_motor, 0);
    check("rst_req_ready", req_ready, 1);
    check("rst_paid_count", paid_count, 0);
    check("rst_fault_done", fault | done, 0);
    req_valid = 1'b0;
    fault_clr = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    sb.delete();
    paid_model = 0;
    @(negedge clk);
  endtask

  task automatic wait_ready(output bit ok);
    int w;
    w = 0;
    while (!req_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    ok = req_ready;
    if (!ok) begin
      fail_bound("ready_wait", 200);
      reset_pulse();
    end
  endtask

  // Issues one request (called at a falling edge) and waits for its outcome to be retired.
  task automatic do_req(input bit soda, input logic [2:0] chg, input bit hop);
    exp_t e;
    int   w;
    bit   ok;
    bit   silent;
    bit   ill;
    wait_ready(ok);
    hopper_en = hop;
    silent = !soda && chg == 3'd0;
    ill    = chg > 3'd4;
    if (!ill && hop) paid_model = (paid_model + int'(chg) > 255) ? 255 : paid_model + int'(chg);
    e.is_fault    = ill || !hop;
    e.soda_pulses = ill ? 0 : int'(soda);
    e.coin_pulses = ill ? 0 : (hop ? int'(chg) : 1);
    e.paid        = paid_model;
    e.accept_cyc  = cyc;
    e.latency     = ill ? 1 : ((soda && chg == 3'd0) ? int'(PULSE) + 1 : -1);
    e.tmo_chk     = !ill && !hop;
    if (!silent) sb.push_back(e);
    req_valid  = 1'b1;
    req_soda   = soda;
    req_change = chg;
    @(negedge clk);
    req_valid  = 1'b0;
    req_soda   = 1'($urandom);
    req_change = 3'($urandom);
    if (silent) begin
      check("silent_ready", req_ready, 1);
      check("silent_no_pulse", soda_motor | coin_eject, 0);
      return;
    end
    w = 0;
    while (sb.size() != 0 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (sb.size() != 0) begin
      fail_bound("completion_wait", 3000);
      reset_pulse();
      return;
    end
    if (e.is_fault) begin
      check("fault_held", fault, 1);
      check("fault_not_ready", req_ready, 0);
      fault_clr = 1'b1;
      @(negedge clk);
      fault_clr = 1'b0;
      check("ready_after_clr", req_ready, 1);
      check("fault_cleared", fault, 0);
    end
  endtask

  // Hopper model: confirms each ejected coin after a short random delay; optional spurious pulses.
  initial begin : hopper
    bit prev;
    bit pend;
    int dly;
    coin_sensed = 1'b0;
    prev = 1'b0;
    pend = 1'b0;
    dly  = 0;
    forever begin
      @(negedge clk);
      coin_sensed = 1'b0;
      if (reset) begin
        prev = 1'b0;
        pend = 1'b0;
      end else if (coin_eject) begin
        prev = 1'b1;
        if (spur_en && $urandom_range(0, 3) == 0) coin_sensed = 1'b1;
      end else begin
        if (prev && hopper_en) begin
          pend = 1'b1;
          dly  = $urandom_range(1, 3);
        end
        prev = 1'b0;
        if (pend) begin
          if (dly <= 1) begin
            coin_sensed = 1'b1;
            pend = 1'b0;
          end else begin
            dly--;
          end
        end else if (spur_en && req_ready && $urandom_range(0, 3) == 0) begin
          coin_sensed = 1'b1;
        end
      end
    end
  end

  // Monitor: measures pulse widths/counts and retires scoreboard entries on done or fault.
  initial begin : monitor
    int   soda_n;
    int   coin_n;
    int   sw;
    int   cw;
    int   since;
    bit   ready_chk;
    bit   fault_q;
    exp_t e;
    soda_n = 0; coin_n = 0; sw = 0; cw = 0; since = 0; ready_chk = 0; fault_q = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        soda_n = 0; coin_n = 0; sw = 0; cw = 0; since = 0; ready_chk = 0; fault_q = 0;
        continue;
      end
      if (ready_chk) begin
        check("ready_after_done", req_ready, 1);
        check("done_one_cycle", done, 0);
        ready_chk = 0;
      end
      if (soda_motor || coin_eject) check("actuator_exclusive", soda_motor & coin_eject, 0);
      if (soda_motor) sw++;
      else if (sw > 0) begin
        check("soda_pulse_width", sw, PULSE);
        soda_n++;
        sw = 0;
      end
      if (coin_eject) begin
        cw++;
        since = 0;
      end else begin
        if (cw > 0) begin
          check("coin_pulse_width", cw, PULSE);
          coin_n++;
          cw = 0;
        end
        since++;
      end
      if (done || (fault && !fault_q)) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_completion: done=%0b fault=%0b with nothing outstanding (cycle %0d)",
                   done, fault, cyc);
        end else begin
          e = sb.pop_front();
          check("outcome_fault", fault, e.is_fault);
          check("outcome_done", done, !e.is_fault);
          check("soda_pulses", soda_n, e.soda_pulses);
          check("coin_pulses", coin_n, e.coin_pulses);
          check("paid_count", paid_count, e.paid);
          if (e.latency >= 0) check("latency", cyc - e.accept_cyc, e.latency);
          if (e.tmo_chk) check("timeout_cycles", since - 1, TMO);
        end
        soda_n = 0;
        coin_n = 0;
        if (done) ready_chk = 1;
      end
      fault_q = fault;
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int  pulses;
    int  hi;
    int  w;
    int  exp_paid;
    bit  ok;
    bit  seen;
    n_checks = 0; n_fail = 0; cyc = 0; paid_model = 0;
    hopper_en = 1'b1; spur_en = 1'b0;
    reset = 1'b0; req_valid = 1'b0; req_soda = 1'b0; req_change = 3'd0; fault_clr = 1'b0;
    @(negedge clk);
    reset_pulse();

    // Directed cases: soda only, soda plus change, illegal change, silent request.
    do_req(1'b1, 3'd0, 1'b1);
    do_req(1'b1, 3'd3, 1'b1);
    do_req(1'b0, 3'd7, 1'b1);
    do_req(1'b0, 3'd0, 1'b1);
    do_req(1'b0, 3'd4, 1'b1);

    spur_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      do_req(1'($urandom), ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4)),
             1'b1);
    end

    // Hopper silent: timeout fault when enabled, indefinite wait otherwise.
`ifdef CHANGE_DISPENSER_TIMEOUT_EN
    do_req(1'b0, 3'd2, 1'b0);
`else
    wait_ready(ok);
    hopper_en  = 1'b0;
    req_valid  = 1'b1;
    req_soda   = 1'b0;
    req_change = 3'd2;
    @(negedge clk);
    req_valid = 1'b0;
    seen = 1'b0;
    repeat (1000) begin
      @(negedge clk);
      if (fault) seen = 1'b1;
    end
    check("no_timeout_fault", seen, 0);
    reset_pulse();
`endif
    hopper_en = 1'b1;

    // Reset during the 2nd cycle of the 2nd coin pulse, after one coin was confirmed.
    spur_en = 1'b0;
    wait_ready(ok);
    exp_paid   = (paid_model + 1 > 255) ? 255 : paid_model + 1;
    req_valid  = 1'b1;
    req_soda   = 1'b0;
    req_change = 3'd3;
    @(negedge clk);
    req_valid = 1'b0;
    pulses = 0; hi = 0; w = 0;
    while (w < 500) begin
      if (coin_eject) begin
        hi++;
        if (hi == 1) pulses++;
        if (pulses == 2 && hi == 2) break;
      end else begin
        hi = 0;
      end
      @(negedge clk);
      w++;
    end
    if (w >= 500) fail_bound("second_pulse_wait", 500);
    check("paid_before_reset", paid_count, exp_paid);
    check("eject_before_reset", coin_eject, 1);
    reset_pulse();
    check("ready_after_reset", req_ready, 1);
    check("paid_after_reset", paid_count, 0);

    // 300 confirmed coins with spurious sensor pulses: count saturates.
    spur_en = 1'b1;
    for (int i = 0; i < 75; i++) do_req(1'b0, 3'd4, 1'b1);
    repeat (2) @(negedge clk);
    check("paid_saturated", paid_count, 255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
